// File: rtl/dummy32_dbg_pkg.sv
// Shared definitions for the cycle-count debug readout path.
//   rpt_state_t    : report sequencer states
//   ASCII_*        : fixed characters of a report line
//   hex_to_ascii() : nibble to uppercase ASCII hex digit
package dummy32_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PFX0 = 3'd1,
        PFX1 = 3'd2,
        DIG  = 3'd3,
        CR   = 3'd4,
        LF   = 3'd5
    } rpt_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return ASCII_0 + wide;
        end
        return 8'h41 + (wide - 8'd10);
    endfunction

endpackage

// File: rtl/cycle_count_reporter.sv
// Snapshots a cycle count on request and streams it as an ASCII hex line
// ("0x0000ABCD\r\n" at defaults) over a byte-wide valid/ready interface.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for snapshot; nothing on the stream
// PFX0      | presenting '0' of the "0x" prefix
// PFX1      | presenting 'x' of the "0x" prefix
// DIG       | presenting hex digit idx (MSB first, idx counts down)
// CR        | presenting carriage return
// LF        | presenting line feed; its transfer ends the report
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous reset, active-high
//   count      live count, sampled only when a snapshot is accepted
//   snapshot   report request, level sampled each cycle
//   out_valid  out_data holds a byte to transfer
//   out_data   ASCII byte
//   out_ready  sink accepts the byte this cycle
//   busy       report in progress
//   overrun    one-cycle pulse: snapshot dropped because a report was running
module cycle_count_reporter
    import dummy32_dbg_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit PREFIX_EN = 1'b1,
    parameter bit EOL_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             snapshot,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int NDIG = WIDTH / 4;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

    rpt_state_t       state_q, state_d;
    logic [WIDTH-1:0] latch_q, latch_d;
    logic [IDXW-1:0]  idx_q,   idx_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q,  data_d;
    logic             ovr_q,   ovr_d;
    logic             xfer;

    assign xfer = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        idx_d   = idx_q;
        ovr_d   = snapshot && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (snapshot) begin
                    latch_d = count;
                    idx_d   = IDX_TOP;
                    state_d = PREFIX_EN ? PFX0 : DIG;
                end
            end
            PFX0: if (xfer) state_d = PFX1;
            PFX1: begin
                if (xfer) begin
                    state_d = DIG;
                    idx_d   = IDX_TOP;
                end
            end
            DIG: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        state_d = EOL_EN ? CR : IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            CR:      if (xfer) state_d = LF;
            LF:      if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The output byte is registered from the next state, so a stalled
    // transfer (state unchanged) re-presents the identical byte.
    always_comb begin
        valid_d = (state_d != IDLE);
        data_d  = 8'h00;
        unique case (state_d)
            PFX0:    data_d = ASCII_0;
            PFX1:    data_d = ASCII_X;
            DIG:     data_d = hex_to_ascii(latch_d[{idx_d, 2'b00} +: 4]);
            CR:      data_d = ASCII_CR;
            LF:      data_d = ASCII_LF;
            default: data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            latch_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_cycle_count_reporter.sv
module tb_cycle_count_reporter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] count_a;
    logic        snap_a;
    logic        va, oa, busy_a;
    logic [7:0]  da;
    logic [15:0] count_b;
    logic        snap_b;
    logic        vb, ob, busy_b;
    logic [7:0]  db;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    cycle_count_reporter #(.WIDTH(32), .PREFIX_EN(1'b1), .EOL_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .count(count_a), .snapshot(snap_a),
        .out_valid(va), .out_data(da), .out_ready(out_ready),
        .busy(busy_a), .overrun(oa)
    );

    cycle_count_reporter #(.WIDTH(16), .PREFIX_EN(1'b0), .EOL_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .count(count_b), .snapshot(snap_b),
        .out_valid(vb), .out_data(db), .out_ready(out_ready),
        .busy(busy_b), .overrun(ob)
    );

    // Reference: the text a human would write for the value, byte by byte.
    function automatic void build_line(input logic [31:0] v, input int ndig,
                                       input bit pfx, input bit eol);
        int n;
        exp_q.delete();
        if (pfx) begin
            exp_q.push_back("0");
            exp_q.push_back("x");
        end
        for (int i = ndig - 1; i >= 0; i--) begin
            n = int'((v >> (4 * i)) % 16);
            if (n < 10) exp_q.push_back(8'("0" + n));
            else        exp_q.push_back(8'("A" + n - 10));
        end
        if (eol) begin
            exp_q.push_back(8'd13);
            exp_q.push_back(8'd10);
        end
    endfunction

    // Called at a negedge; leaves the bench at the negedge of cycle N+1.
    task automatic start(input bit sel, input logic [31:0] v, input string name);
        if (sel) begin count_b = v[15:0]; snap_b = 1'b1; end
        else     begin count_a = v;       snap_a = 1'b1; end
        @(negedge clk);
        snap_a = 1'b0;
        snap_b = 1'b0;
        checks++;
        if ((sel ? {busy_b, vb} : {busy_a, va}) !== 2'b11) begin
            errors++;
            $display("FAIL %s first_byte busy/valid got %b want 11", name,
                     sel ? {busy_b, vb} : {busy_a, va});
        end
    endtask

    // mode 0: ready always 1; 1: ready pattern 1,0,0; 2: random ready
    task automatic collect(input bit sel, input int mode, input string name);
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic v, o, r;
        logic [7:0] d;
        int bad;
        got_q.delete();
        while (got_q.size() < exp_q.size() && cyc < 400) begin
            v = sel ? vb : va;
            d = sel ? db : da;
            o = sel ? ob : oa;
            checks++;
            if (o !== 1'b0) begin
                errors++;
                $display("FAIL %s overrun got %b want 0 (cycle %0d)", name, o, cyc);
            end
            if (stalled) begin
                checks++;
                if (v !== 1'b1 || d !== held) begin
                    errors++;
                    $display("FAIL %s stall_hold got v=%b d=%h want v=1 d=%h", name, v, d, held);
                end
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (v === 1'b1 && r) got_q.push_back(d);
            stalled = (v === 1'b1) && !r;
            held = d;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (mode == 0) begin
            checks++;
            if (cyc != exp_q.size()) begin
                errors++;
                $display("FAIL %s line_cycles got %0d want %0d", name, cyc, exp_q.size());
            end
        end
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad >= 0 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s bytes first bad index %0d got %h want %h (got %0d bytes, want %0d)",
                     name, bad, (bad >= 0 && bad < got_q.size()) ? got_q[bad] : 8'hxx,
                     (bad >= 0) ? exp_q[bad] : 8'hxx, got_q.size(), exp_q.size());
        end
        checks++;
        if ((sel ? busy_b : busy_a) !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after got %b want 0", name, sel ? busy_b : busy_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({va, da, busy_a, oa} !== 11'b0) begin
            errors++;
            $display("FAIL reset_in a got v=%b d=%h busy=%b ovr=%b want all 0", va, da, busy_a, oa);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({va, da, busy_a, oa} !== 11'b0) begin
            errors++;
            $display("FAIL reset_after a got v=%b d=%h busy=%b ovr=%b want all 0", va, da, busy_a, oa);
        end
        checks++;
        if ({vb, db, busy_b, ob} !== 11'b0) begin
            errors++;
            $display("FAIL reset_after b got v=%b d=%h busy=%b ovr=%b want all 0", vb, db, busy_b, ob);
        end
    endtask

    task automatic test_basic();
        build_line(32'h0000_1234, 8, 1, 1);
        start(0, 32'h0000_1234, "basic");
        collect(0, 0, "basic");
    endtask

    task automatic test_stall();
        build_line(32'hDEAD_BEEF, 8, 1, 1);
        start(0, 32'hDEAD_BEEF, "stall");
        collect(0, 1, "stall");
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        v = $urandom;
        build_line(v, 8, 1, 1);
        start(0, v, "overrun");
        got_q.delete();
        for (int k = 1; k <= 20; k++) begin
            checks++;
            if (oa !== (k == 6)) begin
                errors++;
                $display("FAIL overrun_pulse k=%0d got %b want %b", k, oa, (k == 6));
            end
            if (k >= 13) begin
                checks++;
                if (va !== 1'b0) begin
                    errors++;
                    $display("FAIL overrun_no_second_report k=%0d got valid %b want 0", k, va);
                end
            end
            if (va === 1'b1) got_q.push_back(da);
            snap_a  = (k == 5);
            count_a = count_a + 32'd1;
            @(negedge clk);
        end
        snap_a = 1'b0;
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL overrun_line got %0d bytes first %h want %0d bytes first %h",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx, exp_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            build_line(v, 8, 1, 1);
            start(0, v, "back_to_back");
            collect(0, 0, "back_to_back");
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        v = $urandom;
        build_line(v, 8, 1, 1);
        start(0, v, "reset_mid");
        repeat (4) @(negedge clk);
        checks++;
        if (da !== exp_q[4]) begin
            errors++;
            $display("FAIL reset_mid digit3 got %h want %h", da, exp_q[4]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({va, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid abort got valid/busy %b want 00", {va, busy_a});
        end
        @(negedge clk);
        v = $urandom;
        build_line(v, 8, 1, 1);
        start(0, v, "reset_mid_after");
        collect(0, 2, "reset_mid_after");
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            build_line(v, 8, 1, 1);
            start(0, v, "random");
            collect(0, 2, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_narrow();
        logic [31:0] v;
        build_line(32'h0000_00AF, 4, 0, 0);
        start(1, 32'h0000_00AF, "narrow");
        collect(1, 0, "narrow");
        checks++;
        if (vb !== 1'b0) begin
            errors++;
            $display("FAIL narrow valid_after got %b want 0", vb);
        end
        for (int i = 0; i < 4; i++) begin
            v = {16'h0, 16'($urandom)};
            build_line(v, 4, 0, 0);
            start(1, v, "narrow_random");
            collect(1, 2, "narrow_random");
        end
    endtask

    initial begin
        rst       = 1'b1;
        count_a   = '0;
        count_b   = '0;
        snap_a    = 1'b0;
        snap_b    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout global bound reached");
        $fatal(1, "timeout");
    end

endmodule
